// File: rtl/timer_st.sv
// Free-running programmable tick generator: emits a one-cycle registered pulse on `timer`
// every `cnt_rst` clock cycles, starting from `cnt_ini` after reset.
module timer_st #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt_ini,
    input  logic [WIDTH-1:0] cnt_rst,
    output logic             timer
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             timer_q, timer_d;
    logic             terminal;

    // Periods 0 and 1 are both "every edge"; this also keeps cnt_rst-1 from underflowing.
    always_comb begin
        terminal = 1'b0;
        if (cnt_rst <= One) begin
            terminal = 1'b1;
        end else begin
            terminal = (count_q >= (cnt_rst - One));
        end
    end

    always_comb begin
        count_d = count_q + One;
        timer_d = 1'b0;
        if (terminal) begin
            count_d = '0;
            timer_d = 1'b1;
        end
    end

    // Reset loads the live cnt_ini value, so a pending tick is discarded immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= cnt_ini;
            timer_q <= 1'b0;
        end else begin
            count_q <= count_d;
            timer_q <= timer_d;
        end
    end

    assign timer = timer_q;

endmodule

// File: tb/tb_timer_st.sv
// Directed, table-driven bench for timer_st: per-cycle vectors plus hand-written
// sequences for asynchronous reset behaviour.
module tb_timer_st;

    typedef struct {
        string       grp;
        logic        rst_n;
        logic [31:0] ini;
        logic [31:0] per;
        logic        exp_timer;
        logic [31:0] exp_count;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cnt_ini = 32'd5;
    logic [31:0] cnt_rst = 32'd10;
    logic        timer;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t  vecs[$];
    string grp_cur;

    timer_st #(
        .WIDTH(32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cnt_ini(cnt_ini),
        .cnt_rst(cnt_rst),
        .timer  (timer)
    );

    initial forever #5 clk = ~clk;

    task automatic add(input logic r, input logic [31:0] ini, input logic [31:0] per,
                       input logic et, input logic [31:0] ec);
        vec_t v;
        v.grp       = grp_cur;
        v.rst_n     = r;
        v.ini       = ini;
        v.per       = per;
        v.exp_timer = et;
        v.exp_count = ec;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic et, input logic [31:0] ec);
        n_checks++;
        if (timer !== et) begin
            n_fail++;
            $display("FAIL %s timer: got %0b, expected %0b", name, timer, et);
        end
        n_checks++;
        if (dut.count_q !== ec) begin
            n_fail++;
            $display("FAIL %s count: got %0d, expected %0d", name, dut.count_q, ec);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] ini, input logic [31:0] per);
        @(negedge clk);
        reset   = r;
        cnt_ini = ini;
        cnt_rst = per;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset hold: five cycles with reset low.
        grp_cur = "hold";
        for (int i = 0; i < 5; i++) add(1'b0, 32'd5, 32'd10, 1'b0, 32'd5);

        // Basic period 4 from 0: pulses after edges 4, 8, 12.
        grp_cur = "basic";
        add(1'b0, 32'd0, 32'd4, 1'b0, 32'd0);
        for (int e = 1; e <= 12; e++)
            add(1'b1, 32'd0, 32'd4, (e % 4 == 0), 32'(e % 4));

        // Offset start at 2: pulses after edges 2, 6, 10.
        grp_cur = "offset";
        add(1'b0, 32'd2, 32'd4, 1'b0, 32'd2);
        for (int e = 1; e <= 10; e++)
            add(1'b1, 32'd2, 32'd4, ((e + 2) % 4 == 0), 32'((e + 2) % 4));

        grp_cur = "per1";
        add(1'b0, 32'd0, 32'd1, 1'b0, 32'd0);
        for (int e = 1; e <= 3; e++) add(1'b1, 32'd0, 32'd1, 1'b1, 32'd0);

        grp_cur = "per0";
        add(1'b0, 32'd7, 32'd0, 1'b0, 32'd7);
        for (int e = 1; e <= 3; e++) add(1'b1, 32'd7, 32'd0, 1'b1, 32'd0);

        // Start beyond terminal: immediate wrap, then normal period.
        grp_cur = "ini_max";
        add(1'b0, 32'hFFFF_FFFF, 32'd4, 1'b0, 32'hFFFF_FFFF);
        add(1'b1, 32'hFFFF_FFFF, 32'd4, 1'b1, 32'd0);
        add(1'b1, 32'hFFFF_FFFF, 32'd4, 1'b0, 32'd1);
        add(1'b1, 32'hFFFF_FFFF, 32'd4, 1'b0, 32'd2);
        add(1'b1, 32'hFFFF_FFFF, 32'd4, 1'b0, 32'd3);
        add(1'b1, 32'hFFFF_FFFF, 32'd4, 1'b1, 32'd0);

        // Period shrinks from 10 to 5 at count 6; cnt_ini changes while running are ignored.
        grp_cur = "live";
        add(1'b0, 32'd0, 32'd10, 1'b0, 32'd0);
        for (int e = 1; e <= 6; e++) add(1'b1, 32'd9, 32'd10, 1'b0, 32'(e));
        add(1'b1, 32'd9, 32'd5, 1'b1, 32'd0);
        for (int e = 1; e <= 4; e++) add(1'b1, 32'd3, 32'd5, 1'b0, 32'(e));
        add(1'b1, 32'd3, 32'd5, 1'b1, 32'd0);

        // Nominal 1 s period: terminal count is exactly 49,999,999.
        grp_cur = "big";
        add(1'b0, 32'd49_999_997, 32'h02FA_F080, 1'b0, 32'd49_999_997);
        add(1'b1, 32'd49_999_997, 32'h02FA_F080, 1'b0, 32'd49_999_998);
        add(1'b1, 32'd49_999_997, 32'h02FA_F080, 1'b0, 32'd49_999_999);
        add(1'b1, 32'd49_999_997, 32'h02FA_F080, 1'b1, 32'd0);
        add(1'b1, 32'd49_999_997, 32'h02FA_F080, 1'b0, 32'd1);

        // Asynchronous load before any clock edge.
        #2 reset = 1'b0;
        #1 check("async_hold", 1'b0, 32'd5);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].ini, vecs[i].per);
            check($sformatf("%s[%0d]", vecs[i].grp, i), vecs[i].exp_timer, vecs[i].exp_count);
        end

        // Mid-period reset, between edges, while count is 1.
        @(negedge clk);
        reset   = 1'b0;
        cnt_ini = 32'd0;
        cnt_rst = 32'd4;
        #1 check("mid_rst_async", 1'b0, 32'd0);
        for (int e = 1; e <= 4; e++) step(1'b1, 32'd0, 32'd4);
        check("mid_rst_pulse", 1'b1, 32'd0);

        // Reset while the tick is high drops it without waiting for a clock edge.
        @(negedge clk);
        reset   = 1'b0;
        cnt_ini = 32'd1;
        #1 check("tick_drop", 1'b0, 32'd1);
        step(1'b1, 32'd1, 32'd4);
        check("after_rel_e1", 1'b0, 32'd2);
        step(1'b1, 32'd1, 32'd4);
        check("after_rel_e2", 1'b0, 32'd3);
        step(1'b1, 32'd1, 32'd4);
        check("after_rel_e3", 1'b1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
